// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating LSB loads/stores and instruction fetches onto an 8-bit RAM port.
// Optional IO write back-pressure is compiled in with `define MEM_IO_STALL_EN.
module mem_ctrl (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        _clear,
    input  logic        _lsb_mem_ready,
    input  logic        _r_nw_in,
    input  logic [1:0]  _work_type,
    input  logic [31:0] _addr,
    input  logic [31:0] _data_in,
    output logic        _mem_busy,
    output logic        _mem_lsb_ready,
    output logic [31:0] _data_out,
    input  logic        _if_mem_ready,
    input  logic [31:0] _if_addr,
    output logic        _mem_if_ready,
    output logic [31:0] _mem_if_inst,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    typedef enum logic [1:0] {IDLE, LS_READ, LS_WRITE, IF_READ} state_t;

    state_t      state_reg, state_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] data_reg, data_next;
    logic [2:0]  n_reg, n_next;
    logic [2:0]  cyc_reg, cyc_next;
    logic [31:0] shift_reg, shift_next;
    logic [31:0] data_out_reg, data_out_next;
    logic [31:0] inst_reg, inst_next;
    logic        lsb_done_reg, lsb_done_next;
    logic        if_done_reg, if_done_next;
    logic [31:0] mem_a_reg, mem_a_next;
    logic [7:0]  mem_dout_reg, mem_dout_next;
    logic        mem_wr_reg, mem_wr_next;
    logic        io_stall;
    logic [7:0]  store_byte [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_store_byte
            assign store_byte[gi] = data_reg[8*gi +: 8];
        end
    endgenerate

`ifdef MEM_IO_STALL_EN
    // Writes into the IO window (addr[17:16]==11) wait while the IO buffer is full.
    assign io_stall = io_buffer_full && mem_wr_reg && (mem_a_reg[17:16] == 2'b11);
`else
    logic unused_io_full;
    assign unused_io_full = io_buffer_full;
    assign io_stall       = 1'b0;
`endif

    assign _mem_busy      = (state_reg != IDLE);
    assign _mem_lsb_ready = lsb_done_reg & rdy_in;
    assign _mem_if_ready  = if_done_reg & rdy_in;
    assign _data_out      = data_out_reg;
    assign _mem_if_inst   = inst_reg;
    assign mem_a          = mem_a_reg;
    assign mem_dout       = mem_dout_reg;
    assign mem_wr         = mem_wr_reg & rdy_in & ~io_stall;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            data_reg     <= '0;
            n_reg        <= '0;
            cyc_reg      <= '0;
            shift_reg    <= '0;
            data_out_reg <= '0;
            inst_reg     <= '0;
            lsb_done_reg <= 1'b0;
            if_done_reg  <= 1'b0;
            mem_a_reg    <= '0;
            mem_dout_reg <= '0;
            mem_wr_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            data_reg     <= data_next;
            n_reg        <= n_next;
            cyc_reg      <= cyc_next;
            shift_reg    <= shift_next;
            data_out_reg <= data_out_next;
            inst_reg     <= inst_next;
            lsb_done_reg <= lsb_done_next;
            if_done_reg  <= if_done_next;
            mem_a_reg    <= mem_a_next;
            mem_dout_reg <= mem_dout_next;
            mem_wr_reg   <= mem_wr_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        data_next     = data_reg;
        n_next        = n_reg;
        cyc_next      = cyc_reg;
        shift_next    = shift_reg;
        data_out_next = data_out_reg;
        inst_next     = inst_reg;
        lsb_done_next = lsb_done_reg;
        if_done_next  = if_done_reg;
        mem_a_next    = mem_a_reg;
        mem_dout_next = mem_dout_reg;
        mem_wr_next   = mem_wr_reg;

        // With rdy_in low everything holds, including a pending done pulse.
        if (rdy_in) begin
            lsb_done_next = 1'b0;
            if_done_next  = 1'b0;
            case (state_reg)
                IDLE: begin
                    if (!_clear) begin
                        if (_lsb_mem_ready) begin
                            addr_next  = _addr;
                            data_next  = _data_in;
                            n_next     = (_work_type == 2'b00) ? 3'd1 :
                                         (_work_type == 2'b01) ? 3'd2 : 3'd4;
                            cyc_next   = 3'd1;
                            shift_next = '0;
                            mem_a_next = _addr;
                            if (_r_nw_in) begin
                                state_next    = LS_WRITE;
                                mem_wr_next   = 1'b1;
                                mem_dout_next = _data_in[7:0];
                            end else begin
                                state_next = LS_READ;
                            end
                        end else if (_if_mem_ready) begin
                            addr_next  = _if_addr;
                            n_next     = 3'd4;
                            cyc_next   = 3'd1;
                            shift_next = '0;
                            mem_a_next = _if_addr;
                            state_next = IF_READ;
                        end
                    end
                end
                LS_READ, IF_READ: begin
                    if (_clear) begin
                        state_next = IDLE;
                    end else begin
                        // cyc_reg counts cycles since acceptance; bytes arrive one cycle after their address.
                        if (cyc_reg < n_reg)
                            mem_a_next = addr_reg + {29'd0, cyc_reg};
                        if (cyc_reg >= 3'd2)
                            shift_next = {mem_din, shift_reg[31:8]};
                        cyc_next = cyc_reg + 3'd1;
                        if (cyc_reg == n_reg + 3'd1) begin
                            state_next = IDLE;
                            if (state_reg == LS_READ) begin
                                data_out_next = shift_next;
                                lsb_done_next = 1'b1;
                            end else begin
                                inst_next    = shift_next;
                                if_done_next = 1'b1;
                            end
                        end
                    end
                end
                LS_WRITE: begin
                    if (!io_stall) begin
                        if (cyc_reg < n_reg) begin
                            mem_a_next    = addr_reg + {29'd0, cyc_reg};
                            mem_dout_next = store_byte[cyc_reg[1:0]];
                            cyc_next      = cyc_reg + 3'd1;
                        end else begin
                            mem_wr_next   = 1'b0;
                            state_next    = IDLE;
                            lsb_done_next = 1'b1;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

endmodule
